// File: rtl/hc_pkg.sv
// Shared types and constants for the hc_requestor read path.
// Used by hc_rd_arbiter (optional statistics via HC_RD_ARB_STATS_EN).
package hc_pkg;

    localparam int unsigned HC_RD_ARB_MDATA_W = 16;
    localparam int unsigned HC_MAX_REQ        = 16;

    typedef logic [41:0] t_ccip_clAddr;

    typedef logic [$clog2(HC_MAX_REQ)-1:0] t_hc_req_id;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } t_hc_rd_arb_state;

endpackage

// File: rtl/hc_rd_arbiter_if.sv
// Requester-side and CCI-P c0 channel signals of hc_rd_arbiter.
// master = requesters plus CCI-P shell, slave = the arbiter.
interface hc_rd_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    import hc_pkg::*;

    logic [N_REQ-1:0]                   req_valid;
    t_ccip_clAddr [N_REQ-1:0]           req_addr;
    logic [N_REQ-1:0]                   req_ready;
    logic [N_REQ-1:0]                   rsp_valid;
    logic [511:0]                       rsp_data;

    logic                               c0_tx_valid;
    t_ccip_clAddr                       c0_tx_addr;
    logic [HC_RD_ARB_MDATA_W-1:0]       c0_tx_mdata;
    logic                               c0_almfull;
    logic                               c0_rx_valid;
    logic [HC_RD_ARB_MDATA_W-1:0]       c0_rx_mdata;
    logic [511:0]                       c0_rx_data;

    modport master (
        output req_valid, req_addr, c0_almfull, c0_rx_valid, c0_rx_mdata, c0_rx_data,
        input  req_ready, rsp_valid, rsp_data, c0_tx_valid, c0_tx_addr, c0_tx_mdata
    );

    modport slave (
        input  req_valid, req_addr, c0_almfull, c0_rx_valid, c0_rx_mdata, c0_rx_data,
        output req_ready, rsp_valid, rsp_data, c0_tx_valid, c0_tx_addr, c0_tx_mdata
    );

endinterface

// File: rtl/hc_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins, wrapping modulo N.
// The pointer moves past the winner only when advance is asserted.
module hc_rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0]   NUM  = (IW+1)'(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] ptr_q;
    logic [IW:0]   pos;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, ptr_q} + (IW+1)'(i);
            if (pos >= NUM) pos = pos - NUM;
            if (!found && req[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
        if (en && found) gnt[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/hc_rd_arbiter.sv
// Shares the CCI-P c0 read channel among N_REQ requesters with credit and almost-full gating.
// Define HC_RD_ARB_STATS_EN to add per-requester grant/stall counters.
module hc_rd_arbiter
    import hc_pkg::*;
#(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
`ifdef HC_RD_ARB_STATS_EN
    output logic [N_REQ-1:0][31:0] stat_grants,
    output logic [N_REQ-1:0][31:0] stat_stalls,
`endif
    hc_rd_arbiter_if.slave         bus
);

    localparam int unsigned   IW      = $clog2(N_REQ);
    localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned   MW      = HC_RD_ARB_MDATA_W;
    localparam logic [IW:0]   NUM     = (IW+1)'(N_REQ);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    t_hc_rd_arb_state state_q, state_d;
    logic [CW-1:0]    out_q, out_d;
    logic             grant_en, xfer, rx_ok, dec;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx, rx_id;

    logic             tx_valid_q;
    t_ccip_clAddr     tx_addr_q;
    logic [IW-1:0]    tx_id_q;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [511:0]     rsp_data_q;
    logic             done_q, err_q;

    // enable low in RUN already suppresses the grant of the cycle that moves to DRAIN
    assign grant_en = (state_q == RUN) && enable && !bus.c0_almfull && (out_q < MAX_CNT);

    hc_rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .en      (grant_en),
        .adv     (xfer),
        .gnt     (gnt),
        .idx     (gnt_idx)
    );

    assign xfer          = |gnt;
    assign bus.req_ready = gnt;

    // A response is only ours if mdata is exactly a valid requester ID
    assign rx_id = bus.c0_rx_mdata[IW-1:0];
    assign rx_ok = (bus.c0_rx_mdata[MW-1:IW] == '0) && ({1'b0, rx_id} < NUM);
    assign dec   = bus.c0_rx_valid && rx_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN:   if (out_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        if (xfer && !dec) begin
            out_d = out_q + 1'b1;
        end else if (!xfer && dec && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_id_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            tx_valid_q <= xfer;
            if (xfer) begin
                tx_addr_q <= bus.req_addr[gnt_idx];
                tx_id_q   <= gnt_idx;
            end
            rsp_valid_q <= '0;
            if (bus.c0_rx_valid) begin
                rsp_data_q <= bus.c0_rx_data;
                if (rx_ok) rsp_valid_q <= N_REQ'(1) << rx_id;
            end
            done_q <= (state_q == DRAIN) && (out_q == '0);
            if (bus.c0_rx_valid && (!rx_ok || (out_q == '0))) err_q <= 1'b1;
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign err             = err_q;
    assign bus.c0_tx_valid = tx_valid_q;
    assign bus.c0_tx_addr  = tx_addr_q;
    assign bus.c0_tx_mdata = {{(MW - IW){1'b0}}, tx_id_q};
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;

`ifdef HC_RD_ARB_STATS_EN
    // Counters restart with every run so the host reads per-run figures
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else if ((state_q == IDLE) && enable) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (gnt[i]) stat_grants[i] <= stat_grants[i] + 32'd1;
                if (bus.req_valid[i] && !gnt[i]) stat_stalls[i] <= stat_stalls[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hc_rd_arbiter.sv
// Self-checking bench for hc_rd_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_hc_rd_arbiter;
    import hc_pkg::*;

    localparam int unsigned N    = 4;
    localparam int          MAXO = 6;
    localparam int          M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic busy, done, err;

    hc_rd_arbiter_if #(.N_REQ(N)) bus ();

`ifdef HC_RD_ARB_STATS_EN
    logic [N-1:0][31:0] stat_grants, stat_stalls;
`endif

    hc_rd_arbiter #(
        .N_REQ           (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .err         (err),
`ifdef HC_RD_ARB_STATS_EN
        .stat_grants (stat_grants),
        .stat_stalls (stat_stalls),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int           m_state, m_ptr, m_out, m_gidx;
    bit           m_err, m_done, m_tx_valid;
    logic [N-1:0] m_ready, m_rsp_valid;
    logic [41:0]  m_tx_addr;
    logic [15:0]  m_tx_mdata;
    logic [511:0] m_rsp_data;
    int           rq[$];

    task automatic model_reset();
        m_state = M_IDLE; m_ptr = 0; m_out = 0; m_gidx = -1;
        m_err = 0; m_done = 0; m_tx_valid = 0;
        m_ready = '0; m_rsp_valid = '0; m_tx_addr = '0; m_tx_mdata = '0; m_rsp_data = '0;
        rq.delete();
    endtask

    task automatic compute_ready();
        m_ready = '0;
        m_gidx  = -1;
        if (m_state == M_RUN && enable && !bus.c0_almfull && m_out < MAXO) begin
            for (int k = 0; k < int'(N); k++) begin
                int j;
                j = (m_ptr + k) % int'(N);
                if (bus.req_valid[j] && m_gidx < 0) m_gidx = j;
            end
        end
        if (m_gidx >= 0) m_ready[m_gidx] = 1'b1;
    endtask

    task automatic settle();
        #1;
        compute_ready();
    endtask

    // Advance one clock, updating the model from the inputs held across the edge
    task automatic tick();
        int g, md, nstate;
        bit rxv, en, ok, dec;
        logic [41:0] a;
        logic [511:0] rxd;
        compute_ready();
        g = m_gidx;
        a = (g >= 0) ? bus.req_addr[g] : '0;
        rxv = bus.c0_rx_valid; md = int'(bus.c0_rx_mdata); rxd = bus.c0_rx_data; en = enable;
        @(posedge clk);
        ok  = md < int'(N);
        dec = rxv && ok;
        m_done = (m_state == M_DRAIN) && (m_out == 0);
        nstate = m_state;
        if (m_state == M_IDLE && en) nstate = M_RUN;
        if (m_state == M_RUN && !en) nstate = M_DRAIN;
        if (m_state == M_DRAIN && m_out == 0) nstate = M_IDLE;
        m_state = nstate;
        m_tx_valid = (g >= 0);
        if (g >= 0) begin
            m_tx_addr = a; m_tx_mdata = 16'(g); m_ptr = (g + 1) % int'(N);
        end
        m_rsp_valid = '0;
        if (rxv) begin
            m_rsp_data = rxd;
            if (!ok || m_out == 0) m_err = 1;
            if (ok) m_rsp_valid[md] = 1'b1;
        end
        m_out = m_out + ((g >= 0) ? 1 : 0) - (dec ? 1 : 0);
        if (m_out < 0) m_out = 0;
        if (m_tx_valid) rq.push_back(int'(m_tx_mdata));
        @(negedge clk);
    endtask

    task automatic set_rx(input bit v, input int md);
        bus.c0_rx_valid = v;
        bus.c0_rx_mdata = 16'(md);
        for (int i = 0; i < 16; i++) bus.c0_rx_data[i*32 +: 32] = $urandom;
    endtask

    task automatic rand_addr();
        for (int i = 0; i < int'(N); i++) bus.req_addr[i] = {10'($urandom), 32'($urandom)};
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        bus.req_valid = '0;
        bus.c0_almfull = 1'b0;
        set_rx(1'b0, 0);
        rand_addr();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        bus.req_valid = '1;
        settle();
        checks++;
        if ({busy, done, err, bus.c0_tx_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl: busy/done/err/tx=%b want 0000",
                     {busy, done, err, bus.c0_tx_valid});
        end
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_vec: rsp_valid=%b req_ready=%b want 0",
                     bus.rsp_valid, bus.req_ready);
        end
        tick();
    endtask

    task automatic test_fairness();
        int ngrant = 0, cyc = 0;
        int cnt[N];
        do_reset();
        foreach (cnt[j]) cnt[j] = 0;
        enable = 1'b1;
        bus.req_valid = '1;
        while (ngrant < 100 && cyc < 400) begin
            if (rq.size() > 0) set_rx(1'b1, rq.pop_front());
            else set_rx(1'b0, 0);
            rand_addr();
            settle();
            checks++;
            if (bus.req_ready !== m_ready) begin
                errors++;
                $display("FAIL fair_ready: got %b want %b", bus.req_ready, m_ready);
            end
            for (int j = 0; j < int'(N); j++) begin
                if (bus.req_ready[j]) begin
                    checks++;
                    if (j != ngrant % int'(N)) begin
                        errors++;
                        $display("FAIL fair_order: got id %0d want %0d", j, ngrant % int'(N));
                    end
                    cnt[j]++;
                    ngrant++;
                end
            end
            tick();
            checks++;
            if (bus.c0_tx_valid !== m_tx_valid ||
                (m_tx_valid && bus.c0_tx_mdata !== m_tx_mdata)) begin
                errors++;
                $display("FAIL fair_tx: valid=%b mdata=%h want %b %h",
                         bus.c0_tx_valid, bus.c0_tx_mdata, m_tx_valid, m_tx_mdata);
            end
            cyc++;
        end
        checks++;
        if (ngrant != 100) begin
            errors++;
            $display("FAIL fair_timeout: got %0d grants want 100", ngrant);
        end
        for (int j = 0; j < int'(N); j++) begin
            checks++;
            if (cnt[j] != 25) begin
                errors++;
                $display("FAIL fair_share: id %0d got %0d grants want 25", j, cnt[j]);
            end
        end
    endtask

    task automatic test_credit();
        int pulses = 0;
        do_reset();
        enable = 1'b1;
        bus.req_valid = '1;
        for (int c = 0; c < 14; c++) begin
            settle();
            tick();
            if (bus.c0_tx_valid) pulses++;
        end
        checks++;
        if (pulses != MAXO) begin
            errors++;
            $display("FAIL credit_pulses: got %0d want %0d", pulses, MAXO);
        end
        settle();
        checks++;
        if (bus.req_ready !== '0) begin
            errors++;
            $display("FAIL credit_block: req_ready=%b want 0", bus.req_ready);
        end
        set_rx(1'b1, 2);
        tick();
        set_rx(1'b0, 0);
        checks++;
        if (bus.rsp_valid !== 4'b0100) begin
            errors++;
            $display("FAIL credit_rsp: rsp_valid=%b want 0100", bus.rsp_valid);
        end
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            tick();
            if (bus.c0_tx_valid) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL credit_refill: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_almfull();
        int pulses = 0;
        do_reset();
        enable = 1'b1;
        bus.req_valid = '1;
        settle(); tick();
        settle(); tick();
        bus.c0_almfull = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            checks++;
            if (bus.req_ready !== '0) begin
                errors++;
                $display("FAIL af_block: req_ready=%b want 0", bus.req_ready);
            end
            tick();
            if (bus.c0_tx_valid) pulses++;
        end
        checks++;
        if (pulses > 1) begin
            errors++;
            $display("FAIL af_issue: got %0d pulses want at most 1", pulses);
        end
        bus.c0_almfull = 1'b0;
        settle();
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL af_resume: req_ready=%b want 0010", bus.req_ready);
        end
        tick();
    endtask

    task automatic test_drain();
        int pulses = 0;
        bit got = 0;
        do_reset();
        enable = 1'b1;
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            settle(); tick();
        end
        bus.req_valid = '1;
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (bus.req_ready !== '0) begin
                errors++;
                $display("FAIL drain_ready: req_ready=%b want 0", bus.req_ready);
            end
            tick();
            if (bus.c0_tx_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_hold: pulses=%0d busy=%b want 0 1", pulses, busy);
        end
        enable = 1'b1;  // ignored while draining
        for (int r = 0; r < 3; r++) begin
            set_rx(1'b1, 0);
            settle();
            checks++;
            if (bus.req_ready !== '0 || done !== 1'b0) begin
                errors++;
                $display("FAIL drain_rsp: req_ready=%b done=%b want 0 0", bus.req_ready, done);
            end
            tick();
        end
        set_rx(1'b0, 0);
        for (int c = 0; c < 6 && !got; c++) begin
            settle(); tick();
            if (done === 1'b1) begin
                got = 1;
                checks++;
                if (busy !== 1'b0 || !m_done) begin
                    errors++;
                    $display("FAIL drain_idle: busy=%b model_done=%b want 0 1", busy, m_done);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL drain_done_timeout: done=%b want 1", done);
        end
        settle(); tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL drain_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_simul();
        int pulses = 0;
        do_reset();
        enable = 1'b1;
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            settle(); tick();
        end
        set_rx(1'b1, 0);
        settle();
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL simul_grant: req_ready=%b want 0001", bus.req_ready);
        end
        tick();
        set_rx(1'b0, 0);
        for (int c = 0; c < 8; c++) begin
            settle(); tick();
            if (bus.c0_tx_valid) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL simul_count: got %0d pulses want 1", pulses);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL simul_err_pre: err=%b want 0", err);
        end
        set_rx(1'b1, 16'h0007);
        tick();
        set_rx(1'b0, 0);
        checks++;
        if (bus.rsp_valid !== '0 || err !== 1'b1) begin
            errors++;
            $display("FAIL simul_bad_id: rsp_valid=%b err=%b want 0 1", bus.rsp_valid, err);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        enable = 1'b1;
        bus.req_valid = 4'b0001;
        settle(); tick();
        settle(); tick();
        set_rx(1'b1, 0);
        settle(); tick();
        set_rx(1'b0, 0);
        checks++;
        if (bus.c0_tx_valid !== 1'b1 || bus.rsp_valid !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_pre: tx=%b rsp=%b want 1 0001", bus.c0_tx_valid, bus.rsp_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.c0_tx_valid, busy, err, bus.rsp_valid, bus.req_ready} !== '0) begin
            errors++;
            $display("FAIL rmid_clear: tx=%b busy=%b err=%b rsp=%b rdy=%b want all 0",
                     bus.c0_tx_valid, busy, err, bus.rsp_valid, bus.req_ready);
        end
        model_reset();
        enable = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        set_rx(1'b1, 1);
        settle(); tick();
        set_rx(1'b0, 0);
        checks++;
        if (err !== 1'b1 || bus.rsp_valid !== 4'b0010) begin
            errors++;
            $display("FAIL rmid_stale: err=%b rsp=%b want 1 0010", err, bus.rsp_valid);
        end
        enable = 1'b1;
        bus.req_valid = '1;
        for (int c = 0; c < 14; c++) begin
            settle(); tick();
            if (bus.c0_tx_valid) pulses++;
        end
        checks++;
        if (pulses != MAXO) begin
            errors++;
            $display("FAIL rmid_credit: got %0d pulses want %0d", pulses, MAXO);
        end
    endtask

    task automatic test_random();
        do_reset();
        enable = 1'b1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            bus.req_valid  = N'($urandom);
            bus.c0_almfull = ($urandom_range(0, 4) == 0);
            enable         = ($urandom_range(0, 15) != 0);
            rand_addr();
            if (rq.size() > 0 && $urandom_range(0, 2) != 0) set_rx(1'b1, rq.pop_front());
            else if ($urandom_range(0, 40) == 0) set_rx(1'b1, int'($urandom_range(4, 65535)));
            else set_rx(1'b0, 0);
            settle();
            checks++;
            if (bus.req_ready !== m_ready) begin
                errors++;
                $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc, bus.req_ready, m_ready);
            end
            tick();
            checks++;
            if (bus.c0_tx_valid !== m_tx_valid || (m_tx_valid &&
                (bus.c0_tx_mdata !== m_tx_mdata || bus.c0_tx_addr !== m_tx_addr))) begin
                errors++;
                $display("FAIL rnd_tx: cyc %0d got %b %h %h want %b %h %h", cyc,
                         bus.c0_tx_valid, bus.c0_tx_mdata, bus.c0_tx_addr,
                         m_tx_valid, m_tx_mdata, m_tx_addr);
            end
            checks++;
            if (bus.rsp_valid !== m_rsp_valid ||
                (m_rsp_valid != '0 && bus.rsp_data !== m_rsp_data)) begin
                errors++;
                $display("FAIL rnd_rsp: cyc %0d rsp_valid=%b want %b (data match %b)", cyc,
                         bus.rsp_valid, m_rsp_valid, bus.rsp_data === m_rsp_data);
            end
            checks++;
            if ({busy, done, err} !== {m_state != M_IDLE, m_done, m_err}) begin
                errors++;
                $display("FAIL rnd_ctl: cyc %0d busy/done/err=%b want %b", cyc,
                         {busy, done, err}, {m_state != M_IDLE, m_done, m_err});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_credit();
        test_almfull();
        test_drain();
        test_simul();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
